// File: rtl/sramlike_arbiter_if.sv
// Bundle of the inst/data requester ports and the shared sram-like port.
// slave is the arbiter's view; master is the surrounding system's view.
interface sramlike_arbiter_if;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic [31:0] inst_rdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_addr_ok;
   logic        data_data_ok;

   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;

   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output inst_rdata, inst_addr_ok, inst_data_ok,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_addr_ok, data_data_ok,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_rdata, mem_addr_ok, mem_data_ok
   );

   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  inst_rdata, inst_addr_ok, inst_data_ok,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_addr_ok, data_data_ok,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_rdata, mem_addr_ok, mem_data_ok
   );
endinterface

// File: rtl/sramlike_arbiter.sv
// Two-to-one sram-like arbiter: inst and data requesters share one port.
// One transaction in flight; ties go to data or alternate (ARB_MODE).
module sramlike_arbiter #(
   parameter int unsigned ARB_MODE = 0
) (
   input logic               aclk,
   input logic               aresetn,
   sramlike_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_e;

   localparam logic G_INST = 1'b0;
   localparam logic G_DATA = 1'b1;

   state_e state_q, state_d;
   logic   grant_q, grant_d;
   logic   last_q, last_d;
   logic   tie_pick;
   logic   pick;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         grant_q <= G_DATA;
         last_q  <= G_INST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign tie_pick = (ARB_MODE == 0) ? G_DATA : ~last_q;

   always_comb begin
      pick = G_INST;
      if (bus.inst_req && bus.data_req) begin
         pick = tie_pick;
      end else if (bus.data_req) begin
         pick = G_DATA;
      end
   end

   assign bus.inst_rdata = bus.mem_rdata;
   assign bus.data_rdata = bus.mem_rdata;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;

      bus.mem_req   = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_size  = 2'd0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;

      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.inst_req || bus.data_req) begin
               state_d = S_ADDR;
               grant_d = pick;
               last_d  = pick;
            end
         end
         S_ADDR: begin
            bus.mem_req = 1'b1;
            if (grant_q == G_DATA) begin
               bus.mem_wr    = bus.data_wr;
               bus.mem_size  = bus.data_size;
               bus.mem_addr  = bus.data_addr;
               bus.mem_wdata = bus.data_wdata;
            end else begin
               bus.mem_wr    = bus.inst_wr;
               bus.mem_size  = bus.inst_size;
               bus.mem_addr  = bus.inst_addr;
               bus.mem_wdata = bus.inst_wdata;
            end
            // data_ok alone is not meaningful before the address is taken
            if (bus.mem_addr_ok) begin
               bus.data_addr_ok = (grant_q == G_DATA);
               bus.inst_addr_ok = (grant_q == G_INST);
               if (bus.mem_data_ok) begin
                  bus.data_data_ok = (grant_q == G_DATA);
                  bus.inst_data_ok = (grant_q == G_INST);
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.mem_data_ok) begin
               bus.data_data_ok = (grant_q == G_DATA);
               bus.inst_data_ok = (grant_q == G_INST);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed bench for sramlike_arbiter in both arbitration modes.
// Expected grant addresses are queued at request time and popped at mem_req.
module tb_sramlike_arbiter;

   typedef struct packed {
      logic        is_data;
      logic [31:0] addr;
   } exp_t;

   logic aclk;
   logic aresetn;

   int n_cmp;
   int n_bad;

   exp_t q0[$];
   exp_t q1[$];

   sramlike_arbiter_if b0 ();
   sramlike_arbiter_if b1 ();

   sramlike_arbiter #(.ARB_MODE(0)) u0 (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (b0)
   );

   sramlike_arbiter #(.ARB_MODE(1)) u1 (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (b1)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic mid();
      @(negedge aclk);
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
         $error("%s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop0(string tag);
      exp_t e;
      if (q0.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s observed=mem_req expected=no_grant", tag);
      end else begin
         e = q0.pop_front();
         chk32(tag, b0.mem_addr, e.addr);
      end
   endtask

   task automatic clear_bus0();
      b0.inst_req = 0; b0.inst_wr = 0; b0.inst_size = 0;
      b0.inst_addr = 0; b0.inst_wdata = 0;
      b0.data_req = 0; b0.data_wr = 0; b0.data_size = 0;
      b0.data_addr = 0; b0.data_wdata = 0;
      b0.mem_rdata = 0; b0.mem_addr_ok = 0; b0.mem_data_ok = 0;
   endtask

   task automatic clear_bus1();
      b1.inst_req = 0; b1.inst_wr = 0; b1.inst_size = 0;
      b1.inst_addr = 0; b1.inst_wdata = 0;
      b1.data_req = 0; b1.data_wr = 0; b1.data_size = 0;
      b1.data_addr = 0; b1.data_wdata = 0;
      b1.mem_rdata = 0; b1.mem_addr_ok = 0; b1.mem_data_ok = 0;
   endtask

   initial begin
      exp_t e;
      int   w;
      n_cmp   = 0;
      n_bad   = 0;
      aresetn = 1'b0;
      clear_bus0();
      clear_bus1();

      // reset state
      mid();
      chk1("rst_mem_req0", b0.mem_req, 1'b0);
      chk32("rst_mem_addr0", b0.mem_addr, 32'h0);
      chk1("rst_iaok0", b0.inst_addr_ok, 1'b0);
      chk1("rst_ddok0", b0.data_data_ok, 1'b0);
      chk1("rst_mem_req1", b1.mem_req, 1'b0);
      step();
      aresetn = 1'b1;

      // mode 0 tie: data first, inst stays pending
      step();
      b0.data_req  = 1; b0.data_addr = 32'h0000_1000;
      b0.inst_req  = 1; b0.inst_addr = 32'hBFC0_0000;
      q0.push_back('{1'b1, 32'h0000_1000});
      q0.push_back('{1'b0, 32'hBFC0_0000});
      mid();
      chk1("A_c1_idle", b0.mem_req, 1'b0);
      step();
      b0.mem_addr_ok = 1;
      mid();
      chk1("A_c2_req", b0.mem_req, 1'b1);
      pop0("A_c2_addr");
      chk1("A_c2_daok", b0.data_addr_ok, 1'b1);
      chk1("A_c2_iaok", b0.inst_addr_ok, 1'b0);
      step();
      b0.data_req = 0; b0.mem_addr_ok = 0;
      b0.mem_data_ok = 1; b0.mem_rdata = 32'h1111_2222;
      mid();
      chk1("A_c3_req", b0.mem_req, 1'b0);
      chk1("A_c3_ddok", b0.data_data_ok, 1'b1);
      chk1("A_c3_idok", b0.inst_data_ok, 1'b0);
      chk32("A_c3_drd", b0.data_rdata, 32'h1111_2222);
      step();
      b0.mem_data_ok = 0;
      mid();
      chk1("A_c4_idle", b0.mem_req, 1'b0);
      step();
      b0.mem_addr_ok = 1; b0.mem_data_ok = 1;
      mid();
      chk1("A_c5_req", b0.mem_req, 1'b1);
      pop0("A_c5_addr");
      chk1("A_c5_iaok", b0.inst_addr_ok, 1'b1);
      chk1("A_c5_idok", b0.inst_data_ok, 1'b1);
      chk1("A_c5_daok", b0.data_addr_ok, 1'b0);
      step();
      clear_bus0();
      mid();
      chk1("A_c6_idle", b0.mem_req, 1'b0);

      // inst read with split handshakes and a stray early data_ok
      step();
      b0.inst_req = 1; b0.inst_addr = 32'hBFC0_0004;
      q0.push_back('{1'b0, 32'hBFC0_0004});
      mid();
      chk1("B_c1_idle", b0.mem_req, 1'b0);
      step();
      b0.inst_req = 0; b0.mem_data_ok = 1;
      mid();
      chk1("B_c2_req", b0.mem_req, 1'b1);
      pop0("B_c2_addr");
      chk1("B_c2_iaok", b0.inst_addr_ok, 1'b0);
      chk1("B_c2_idok", b0.inst_data_ok, 1'b0);
      step();
      b0.mem_data_ok = 0; b0.mem_addr_ok = 1;
      mid();
      chk1("B_c3_hold", b0.mem_req, 1'b1);
      chk1("B_c3_iaok", b0.inst_addr_ok, 1'b1);
      chk1("B_c3_daok", b0.data_addr_ok, 1'b0);
      chk1("B_c3_idok", b0.inst_data_ok, 1'b0);
      step();
      b0.mem_addr_ok = 0;
      mid();
      chk1("B_c4_req", b0.mem_req, 1'b0);
      chk1("B_c4_iaok", b0.inst_addr_ok, 1'b0);
      step();
      mid();
      chk1("B_c5_idok", b0.inst_data_ok, 1'b0);
      step();
      b0.mem_data_ok = 1; b0.mem_rdata = 32'h2408_0001;
      mid();
      chk1("B_c6_idok", b0.inst_data_ok, 1'b1);
      chk32("B_c6_ird", b0.inst_rdata, 32'h2408_0001);
      chk32("B_c6_drd", b0.data_rdata, 32'h2408_0001);
      chk1("B_c6_ddok", b0.data_data_ok, 1'b0);
      chk1("B_c6_daok", b0.data_addr_ok, 1'b0);
      step();
      b0.mem_data_ok = 0;
      mid();
      chk1("B_c7_idok", b0.inst_data_ok, 1'b0);
      chk1("B_c7_req", b0.mem_req, 1'b0);

      // data write with addr_ok and data_ok together
      step();
      b0.data_req = 1; b0.data_wr = 1; b0.data_size = 2'd2;
      b0.data_addr = 32'h0000_2000; b0.data_wdata = 32'hDEAD_BEEF;
      q0.push_back('{1'b1, 32'h0000_2000});
      mid();
      chk1("C_c1_idle", b0.mem_req, 1'b0);
      step();
      b0.mem_addr_ok = 1; b0.mem_data_ok = 1;
      mid();
      pop0("C_c2_addr");
      chk1("C_c2_wr", b0.mem_wr, 1'b1);
      chk32("C_c2_size", {30'd0, b0.mem_size}, 32'd2);
      chk32("C_c2_wdata", b0.mem_wdata, 32'hDEAD_BEEF);
      chk1("C_c2_daok", b0.data_addr_ok, 1'b1);
      chk1("C_c2_ddok", b0.data_data_ok, 1'b1);
      step();
      b0.mem_addr_ok = 0; b0.mem_data_ok = 0;
      b0.data_wr = 0; b0.data_addr = 32'h0000_2004;
      q0.push_back('{1'b1, 32'h0000_2004});
      mid();
      chk1("C_c3_idle", b0.mem_req, 1'b0);
      step();
      b0.mem_addr_ok = 1; b0.mem_data_ok = 1;
      mid();
      chk1("C_c4_req", b0.mem_req, 1'b1);
      pop0("C_c4_addr");
      chk1("C_c4_wr", b0.mem_wr, 1'b0);
      step();
      clear_bus0();
      mid();
      chk1("C_c5_idle", b0.mem_req, 1'b0);

      // reset in DATA, then a late data_ok
      step();
      b0.inst_req = 1; b0.inst_addr = 32'hBFC0_0008;
      q0.push_back('{1'b0, 32'hBFC0_0008});
      step();
      b0.inst_req = 0; b0.mem_addr_ok = 1;
      mid();
      pop0("D_addr");
      chk1("D_iaok", b0.inst_addr_ok, 1'b1);
      step();
      b0.mem_addr_ok = 0;
      mid();
      chk1("D_data_req", b0.mem_req, 1'b0);
      step();
      aresetn = 1'b0;
      mid();
      chk1("D_rst_req", b0.mem_req, 1'b0);
      chk1("D_rst_idok", b0.inst_data_ok, 1'b0);
      step();
      aresetn = 1'b1;
      step();
      b0.mem_data_ok = 1;
      mid();
      chk1("D_late_idok", b0.inst_data_ok, 1'b0);
      chk1("D_late_ddok", b0.data_data_ok, 1'b0);
      chk1("D_late_req", b0.mem_req, 1'b0);
      step();
      b0.mem_data_ok = 0;
      mid();
      chk1("D_after_req", b0.mem_req, 1'b0);

      // mode 1: continuous tie alternates starting with data
      step();
      b1.data_req = 1; b1.data_addr = 32'h0000_00D0;
      b1.inst_req = 1; b1.inst_addr = 32'h0000_0010;
      for (int t = 0; t < 4; t++) begin
         q1.push_back(exp_t'{(t % 2 == 0), (t % 2 == 0) ? 32'hD0 : 32'h10});
      end
      for (int t = 0; t < 4; t++) begin
         w = 0;
         mid();
         while (!b1.mem_req && w < 8) begin
            step();
            mid();
            w++;
         end
         if (!b1.mem_req) begin
            n_cmp++;
            n_bad++;
            $display("FAIL E_wait%0d observed=timeout expected=mem_req", t);
         end else if (q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL E_q%0d observed=mem_req expected=no_grant", t);
         end else begin
            e = q1.pop_front();
            chk32($sformatf("E_addr%0d", t), b1.mem_addr, e.addr);
            b1.mem_addr_ok = 1; b1.mem_data_ok = 1;
            #1;
            chk1($sformatf("E_daok%0d", t), b1.data_addr_ok, e.is_data);
            chk1($sformatf("E_iaok%0d", t), b1.inst_addr_ok, ~e.is_data);
         end
         step();
         b1.mem_addr_ok = 0; b1.mem_data_ok = 0;
      end
      clear_bus1();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
